// File: rtl/bus_responder_pkg.sv
// Shared definitions for bus_responder: I/O register offsets, STATUS bit layout
// and the STATUS byte builder. Optional RX path is enabled by RX_FIFO_EN.
package bus_pkg;

  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_RXDATA = 2'd2;
  localparam logic [1:0] REG_CTRL   = 2'd3;

  localparam int STAT_TX_FULL  = 0;
  localparam int STAT_TX_EMPTY = 1;
  localparam int STAT_RX_AVAIL = 2;
  localparam int STAT_OVF      = 3;

  localparam logic [7:0] UNMAPPED_DATA = 8'hFF;

  typedef enum logic [1:0] {
    REGION_RAM  = 2'd0,
    REGION_IO   = 2'd1,
    REGION_NONE = 2'd2
  } region_e;

  function automatic logic [7:0] status_byte(input logic tx_full,
                                             input logic tx_empty,
                                             input logic rx_avail,
                                             input logic ovf);
    logic [7:0] s;
    s                = 8'h00;
    s[STAT_TX_FULL]  = tx_full;
    s[STAT_TX_EMPTY] = tx_empty;
    s[STAT_RX_AVAIL] = rx_avail;
    s[STAT_OVF]      = ovf;
    return s;
  endfunction

endpackage

// File: rtl/bus_responder_if.sv
// CPU pin bus plus host TX/RX streams. The shared data pins are resolved here
// from the responder and CPU drive enables.
interface bus_responder_if;
  logic [15:0] address;
  logic        read_en;
  wire  [7:0]  data;
  logic [7:0]  m_wdata;
  logic        m_drive;
  logic [7:0]  s_rdata;
  logic        s_drive;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;

  assign data = s_drive ? s_rdata : (m_drive ? m_wdata : 8'hzz);

  modport slave (
    input  address, read_en, data, tx_ready, rx_data, rx_valid,
    output s_rdata, s_drive, tx_data, tx_valid, rx_ready
  );

  modport master (
    output address, read_en, m_wdata, m_drive, tx_ready, rx_data, rx_valid,
    input  data, tx_data, tx_valid, rx_ready
  );
endinterface

// File: rtl/bus_responder_sync_fifo.sv
// Show-ahead synchronous FIFO; push is refused when full and pop when empty,
// both judged on the count at the start of the cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             do_push_s, do_pop_s;

  assign full_o    = (cnt_q == DEPTH_CNT);
  assign empty_o   = (cnt_q == (AW+1)'(0));
  assign head_o    = mem_q[rd_q];
  assign do_push_s = push_i && !full_o;
  assign do_pop_s  = pop_i && !empty_o;

  // pointer and occupancy next state
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push_s) wr_d = wr_q + AW'(1);
    else           wr_d = wr_q;
    if (do_pop_s)  rd_d = rd_q + AW'(1);
    else           rd_d = rd_q;
    case ({do_push_s, do_pop_s})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // pointer and occupancy registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // storage has no reset; only occupied entries are ever observed
  always_ff @(posedge clk_i) begin
    if (do_push_s) mem_q[wr_q] <= din_i;
  end

endmodule

// File: rtl/bus_responder.sv
// CPU bus target: RAM, 4-byte character I/O window with TX FIFO, unmapped
// space. Define RX_FIFO_EN to add the host-to-CPU RX FIFO.
module bus_responder
  import bus_pkg::*;
#(
  parameter int          RAM_AW     = 12,
  parameter logic [15:0] IO_BASE    = 16'hF000,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic            ph2,
  input  logic            reset,
  bus_responder_if.slave  bus
);

  localparam int RAM_WORDS = 2 ** RAM_AW;

  logic [7:0] ram_q [RAM_WORDS];
  logic       ovf_q, ovf_d;
  region_e    region_s;
  logic [1:0] reg_off_s;
  logic       wr_cycle_s, io_s;
  logic       tx_push_req_s, tx_push_s, tx_drop_s, ctrl_clr_s, ram_we_s;
  logic       tx_full_s, tx_empty_s, tx_pop_s;
  logic [7:0] tx_head_s, rd_data_s;
  logic       rx_ready_s, rx_avail_s;
  logic [7:0] rx_rd_s;

  // address decode; the I/O window takes priority over RAM
  always_comb begin
    region_s = REGION_NONE;
    if (bus.address[15:2] == IO_BASE[15:2]) begin
      region_s = REGION_IO;
    end else if ((32'(bus.address) >> RAM_AW) == 32'd0) begin
      region_s = REGION_RAM;
    end else begin
      region_s = REGION_NONE;
    end
  end

  assign reg_off_s     = bus.address[1:0];
  assign io_s          = (region_s == REGION_IO);
  assign wr_cycle_s    = !bus.read_en && !reset;
  assign tx_push_req_s = wr_cycle_s && io_s && (reg_off_s == REG_TXDATA);
  assign tx_push_s     = tx_push_req_s && !tx_full_s;
  assign tx_drop_s     = tx_push_req_s && tx_full_s;
  assign ctrl_clr_s    = wr_cycle_s && io_s && (reg_off_s == REG_CTRL) && bus.data[0];
  assign ram_we_s      = wr_cycle_s && (region_s == REGION_RAM);
  assign tx_pop_s      = bus.tx_valid && bus.tx_ready;

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk_i   (ph2),
    .rst_i   (reset),
    .push_i  (tx_push_s),
    .pop_i   (tx_pop_s),
    .din_i   (bus.data),
    .head_o  (tx_head_s),
    .full_o  (tx_full_s),
    .empty_o (tx_empty_s)
  );

`ifdef RX_FIFO_EN
  logic       rx_full_s, rx_empty_s, rx_push_s, rx_pop_s;
  logic [7:0] rx_head_s;

  assign rx_ready_s = !rx_full_s && !reset;
  assign rx_push_s  = bus.rx_valid && rx_ready_s;
  assign rx_pop_s   = bus.read_en && !reset && io_s && (reg_off_s == REG_RXDATA) && !rx_empty_s;
  assign rx_avail_s = !rx_empty_s;
  assign rx_rd_s    = rx_empty_s ? 8'h00 : rx_head_s;

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk_i   (ph2),
    .rst_i   (reset),
    .push_i  (rx_push_s),
    .pop_i   (rx_pop_s),
    .din_i   (bus.rx_data),
    .head_o  (rx_head_s),
    .full_o  (rx_full_s),
    .empty_o (rx_empty_s)
  );
`else
  logic rx_unused_s;

  assign rx_unused_s = ^{bus.rx_data, bus.rx_valid};
  assign rx_ready_s  = 1'b0;
  assign rx_avail_s  = 1'b0;
  assign rx_rd_s     = 8'h00;
`endif

  // sticky overflow flag next state
  always_comb begin
    ovf_d = ovf_q;
    if (ctrl_clr_s)     ovf_d = 1'b0;
    else if (tx_drop_s) ovf_d = 1'b1;
    else                ovf_d = ovf_q;
  end

  // overflow flag register
  always_ff @(posedge ph2) begin
    if (reset) ovf_q <= 1'b0;
    else       ovf_q <= ovf_d;
  end

  // RAM write port; contents are deliberately not reset
  always_ff @(posedge ph2) begin
    if (ram_we_s) ram_q[bus.address[RAM_AW-1:0]] <= bus.data;
  end

  // combinational read data for the current cycle
  always_comb begin
    rd_data_s = UNMAPPED_DATA;
    if (reset) begin
      rd_data_s = UNMAPPED_DATA;
    end else begin
      case (region_s)
        REGION_IO: begin
          case (reg_off_s)
            REG_STATUS: rd_data_s = status_byte(tx_full_s, tx_empty_s, rx_avail_s, ovf_q);
            REG_RXDATA: rd_data_s = rx_rd_s;
            default:    rd_data_s = 8'h00;
          endcase
        end
        REGION_RAM: rd_data_s = ram_q[bus.address[RAM_AW-1:0]];
        default:    rd_data_s = UNMAPPED_DATA;
      endcase
    end
  end

  assign bus.s_rdata  = rd_data_s;
  assign bus.s_drive  = bus.read_en;
  assign bus.tx_valid = !tx_empty_s && !reset;
  assign bus.tx_data  = (reset || tx_empty_s) ? 8'h00 : tx_head_s;
  assign bus.rx_ready = rx_ready_s;

endmodule

// File: tb/tb_bus_responder.sv
// Directed self-checking bench for bus_responder; RX checks follow RX_FIFO_EN.
module tb_bus_responder;
  import bus_pkg::*;

  logic ph2;
  logic reset;
  int   n_checks;
  int   n_fail;
  logic [7:0] rd;

  bus_responder_if bus ();

  bus_responder dut (
    .ph2   (ph2),
    .reset (reset),
    .bus   (bus)
  );

  initial ph2 = 1'b0;
  always #5 ph2 = ~ph2;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic set_idle();
    bus.address = 16'h8000;
    bus.read_en = 1'b1;
    bus.m_drive = 1'b0;
    bus.m_wdata = 8'h00;
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
    bus.address = a;
    bus.read_en = 1'b0;
    bus.m_drive = 1'b1;
    bus.m_wdata = d;
    @(posedge ph2);
    #1;
    set_idle();
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [7:0] d);
    bus.address = a;
    bus.read_en = 1'b1;
    bus.m_drive = 1'b0;
    @(negedge ph2);
    d = bus.data;
    @(posedge ph2);
    #1;
    set_idle();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.address = 16'h0123;
    bus.read_en = 1'b1;
    @(negedge ph2);
    n_checks++;
    if (bus.tx_valid !== 1'b0) begin n_fail++; $display("FAIL rst_tx_valid: got %b want 0", bus.tx_valid); end
    n_checks++;
    if (bus.tx_data !== 8'h00) begin n_fail++; $display("FAIL rst_tx_data: got %h want 00", bus.tx_data); end
    n_checks++;
    if (bus.rx_ready !== 1'b0) begin n_fail++; $display("FAIL rst_rx_ready: got %b want 0", bus.rx_ready); end
    n_checks++;
    if (bus.data !== 8'hFF) begin n_fail++; $display("FAIL rst_data: got %h want FF", bus.data); end
    @(posedge ph2); #1;
    @(posedge ph2); #1;
    reset = 1'b0;
    set_idle();
    @(negedge ph2);
    n_checks++;
    if (bus.tx_valid !== 1'b0) begin n_fail++; $display("FAIL post_rst_tx_valid: got %b want 0", bus.tx_valid); end
`ifdef RX_FIFO_EN
    n_checks++;
    if (bus.rx_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_rx_ready: got %b want 1", bus.rx_ready); end
`else
    n_checks++;
    if (bus.rx_ready !== 1'b0) begin n_fail++; $display("FAIL post_rst_rx_ready: got %b want 0", bus.rx_ready); end
`endif
    @(posedge ph2); #1;
    bus_read(16'hF001, rd);
    n_checks++;
    if (rd !== 8'h02) begin n_fail++; $display("FAIL post_rst_status: got %h want 02", rd); end
  endtask

  task automatic test_ram();
    bus_write(16'h0123, 8'h5A);
    bus_read(16'h0123, rd);
    n_checks++;
    if (rd !== 8'h5A) begin n_fail++; $display("FAIL ram_rd: got %h want 5A", rd); end
    bus_read(16'h8000, rd);
    n_checks++;
    if (rd !== 8'hFF) begin n_fail++; $display("FAIL unmapped_rd: got %h want FF", rd); end
    bus_write(16'h0FFF, 8'hA7);
    bus_write(16'h1000, 8'h3C);
    bus_read(16'h0FFF, rd);
    n_checks++;
    if (rd !== 8'hA7) begin n_fail++; $display("FAIL ram_top_rd: got %h want A7", rd); end
    bus_read(16'h1000, rd);
    n_checks++;
    if (rd !== 8'hFF) begin n_fail++; $display("FAIL ram_edge_unmapped: got %h want FF", rd); end
    bus_read(16'h0000, rd);
    n_checks++;
    if (rd === 8'h3C) begin n_fail++; $display("FAIL ram_alias: got %h want not 3C", rd); end
  endtask

  task automatic test_tx_overflow();
    bus.tx_ready = 1'b0;
    for (int i = 1; i <= 9; i++) bus_write(16'hF000, 8'(i));
    bus_read(16'hF001, rd);
    n_checks++;
    if (rd !== 8'h09) begin n_fail++; $display("FAIL ovf_status: got %h want 09", rd); end
    bus_read(16'hF000, rd);
    n_checks++;
    if (rd !== 8'h00) begin n_fail++; $display("FAIL txdata_rd: got %h want 00", rd); end
    bus.tx_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge ph2);
      n_checks++;
      if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'(i)) begin
        n_fail++;
        $display("FAIL tx_drain[%0d]: got valid=%b data=%h want valid=1 data=%h", i, bus.tx_valid, bus.tx_data, 8'(i));
      end
      @(posedge ph2); #1;
    end
    @(negedge ph2);
    n_checks++;
    if (bus.tx_valid !== 1'b0) begin n_fail++; $display("FAIL tx_drain_empty: got %b want 0", bus.tx_valid); end
    @(posedge ph2); #1;
    bus.tx_ready = 1'b0;
    bus_write(16'hF003, 8'h00);
    bus_read(16'hF001, rd);
    n_checks++;
    if (rd !== 8'h0A) begin n_fail++; $display("FAIL ctrl0_keeps_ovf: got %h want 0A", rd); end
    bus_write(16'hF003, 8'h01);
    bus_read(16'hF001, rd);
    n_checks++;
    if (rd !== 8'h02) begin n_fail++; $display("FAIL ctrl1_clears_ovf: got %h want 02", rd); end
    bus_read(16'hF003, rd);
    n_checks++;
    if (rd !== 8'h00) begin n_fail++; $display("FAIL ctrl_rd: got %h want 00", rd); end
  endtask

  task automatic test_full_pop_same_cycle();
    bus.tx_ready = 1'b0;
    for (int i = 0; i < 8; i++) bus_write(16'hF000, 8'(8'h10 + i));
    bus_read(16'hF001, rd);
    n_checks++;
    if (rd !== 8'h01) begin n_fail++; $display("FAIL full_status: got %h want 01", rd); end
    bus.tx_ready = 1'b1;
    bus_write(16'hF000, 8'h99);
    bus.tx_ready = 1'b0;
    bus_read(16'hF001, rd);
    n_checks++;
    if (rd !== 8'h08) begin n_fail++; $display("FAIL full_pop_status: got %h want 08", rd); end
    bus_write(16'hF003, 8'h01);
    bus_read(16'hF001, rd);
    n_checks++;
    if (rd !== 8'h00) begin n_fail++; $display("FAIL full_pop_clr: got %h want 00", rd); end
    bus.tx_ready = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      @(negedge ph2);
      n_checks++;
      if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'(8'h10 + i)) begin
        n_fail++;
        $display("FAIL full_pop_drain[%0d]: got valid=%b data=%h want valid=1 data=%h", i, bus.tx_valid, bus.tx_data, 8'(8'h10 + i));
      end
      @(posedge ph2); #1;
    end
    @(negedge ph2);
    n_checks++;
    if (bus.tx_valid !== 1'b0) begin n_fail++; $display("FAIL full_pop_count7: got valid=%b want 0", bus.tx_valid); end
    @(posedge ph2); #1;
    bus.tx_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [7:0] vals [3];
    vals[0] = 8'hB1;
    vals[1] = 8'hB2;
    vals[2] = 8'hB3;
    bus.tx_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.address = 16'hF000;
      bus.read_en = 1'b0;
      bus.m_drive = 1'b1;
      bus.m_wdata = vals[i];
      @(negedge ph2);
      n_checks++;
      if (i == 0) begin
        if (bus.tx_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_first: got valid=%b want 0", bus.tx_valid); end
      end else begin
        if (bus.tx_valid !== 1'b1 || bus.tx_data !== vals[i-1]) begin
          n_fail++;
          $display("FAIL b2b[%0d]: got valid=%b data=%h want valid=1 data=%h", i, bus.tx_valid, bus.tx_data, vals[i-1]);
        end
      end
      @(posedge ph2); #1;
    end
    set_idle();
    @(negedge ph2);
    n_checks++;
    if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'hB3) begin
      n_fail++;
      $display("FAIL b2b_last: got valid=%b data=%h want valid=1 data=B3", bus.tx_valid, bus.tx_data);
    end
    @(posedge ph2); #1;
    @(negedge ph2);
    n_checks++;
    if (bus.tx_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_empty: got %b want 0", bus.tx_valid); end
    @(posedge ph2); #1;
    bus.tx_ready = 1'b0;
  endtask

  task automatic test_rx();
`ifdef RX_FIFO_EN
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'hA1;
    @(posedge ph2); #1;
    bus.rx_data  = 8'hA2;
    @(posedge ph2); #1;
    bus.rx_valid = 1'b0;
    bus_read(16'hF001, rd);
    n_checks++;
    if (rd !== 8'h06) begin n_fail++; $display("FAIL rx_status_avail: got %h want 06", rd); end
    bus_read(16'hF002, rd);
    n_checks++;
    if (rd !== 8'hA1) begin n_fail++; $display("FAIL rx_rd1: got %h want A1", rd); end
    bus_read(16'hF002, rd);
    n_checks++;
    if (rd !== 8'hA2) begin n_fail++; $display("FAIL rx_rd2: got %h want A2", rd); end
    bus_read(16'hF002, rd);
    n_checks++;
    if (rd !== 8'h00) begin n_fail++; $display("FAIL rx_rd_empty: got %h want 00", rd); end
    bus_read(16'hF001, rd);
    n_checks++;
    if (rd !== 8'h02) begin n_fail++; $display("FAIL rx_status_empty: got %h want 02", rd); end
    // write to RXDATA must not pop; then push and pop in one cycle
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'hC1;
    @(posedge ph2); #1;
    bus.rx_valid = 1'b0;
    bus_write(16'hF002, 8'h55);
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'hC2;
    bus_read(16'hF002, rd);
    bus.rx_valid = 1'b0;
    n_checks++;
    if (rd !== 8'hC1) begin n_fail++; $display("FAIL rx_wr_no_pop: got %h want C1", rd); end
    bus_read(16'hF002, rd);
    n_checks++;
    if (rd !== 8'hC2) begin n_fail++; $display("FAIL rx_push_pop: got %h want C2", rd); end
    bus_read(16'hF002, rd);
    n_checks++;
    if (rd !== 8'h00) begin n_fail++; $display("FAIL rx_push_pop_empty: got %h want 00", rd); end
    bus.rx_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      bus.rx_data = 8'(8'hE0 + i);
      @(posedge ph2); #1;
    end
    bus.rx_valid = 1'b0;
    @(negedge ph2);
    n_checks++;
    if (bus.rx_ready !== 1'b0) begin n_fail++; $display("FAIL rx_full_ready: got %b want 0", bus.rx_ready); end
    @(posedge ph2); #1;
    for (int i = 0; i < 8; i++) begin
      bus_read(16'hF002, rd);
      n_checks++;
      if (rd !== 8'(8'hE0 + i)) begin n_fail++; $display("FAIL rx_full_drain[%0d]: got %h want %h", i, rd, 8'(8'hE0 + i)); end
    end
    bus_read(16'hF002, rd);
    n_checks++;
    if (rd !== 8'h00) begin n_fail++; $display("FAIL rx_full_extra: got %h want 00", rd); end
`else
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'h77;
    @(negedge ph2);
    n_checks++;
    if (bus.rx_ready !== 1'b0) begin n_fail++; $display("FAIL rx_tied_ready: got %b want 0", bus.rx_ready); end
    @(posedge ph2); #1;
    bus.rx_valid = 1'b0;
    bus_read(16'hF002, rd);
    n_checks++;
    if (rd !== 8'h00) begin n_fail++; $display("FAIL rx_absent_rd: got %h want 00", rd); end
    bus_read(16'hF001, rd);
    n_checks++;
    if (rd !== 8'h02) begin n_fail++; $display("FAIL rx_absent_status: got %h want 02", rd); end
`endif
  endtask

  task automatic test_reset_mid();
    bus.tx_ready = 1'b0;
    for (int i = 1; i <= 9; i++) bus_write(16'hF000, 8'(8'h20 + i));
    bus.tx_ready = 1'b1;
    repeat (5) begin @(posedge ph2); #1; end
    bus.tx_ready = 1'b0;
    bus_read(16'hF001, rd);
    n_checks++;
    if (rd !== 8'h08 || bus.tx_data !== 8'h26) begin
      n_fail++;
      $display("FAIL mid_pre: got status=%h head=%h want status=08 head=26", rd, bus.tx_data);
    end
    reset = 1'b1;
    bus.address = 16'h0123;
    bus.read_en = 1'b1;
    @(negedge ph2);
    n_checks++;
    if (bus.tx_valid !== 1'b0 || bus.tx_data !== 8'h00 || bus.rx_ready !== 1'b0 || bus.data !== 8'hFF) begin
      n_fail++;
      $display("FAIL mid_rst: got valid=%b data=%h rx_ready=%b bus=%h want 0 00 0 FF", bus.tx_valid, bus.tx_data, bus.rx_ready, bus.data);
    end
    @(posedge ph2); #1;
    reset = 1'b0;
    set_idle();
    @(negedge ph2);
    n_checks++;
    if (bus.tx_valid !== 1'b0) begin n_fail++; $display("FAIL mid_post_valid: got %b want 0", bus.tx_valid); end
    @(posedge ph2); #1;
    bus_read(16'hF001, rd);
    n_checks++;
    if (rd !== 8'h02) begin n_fail++; $display("FAIL mid_post_status: got %h want 02", rd); end
    bus_write(16'h0042, 8'hC3);
    bus_read(16'h0042, rd);
    n_checks++;
    if (rd !== 8'hC3) begin n_fail++; $display("FAIL mid_post_ram: got %h want C3", rd); end
  endtask

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    reset        = 1'b1;
    bus.tx_ready = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    set_idle();
    test_reset();
    test_ram();
    test_tx_overflow();
    test_full_pop_same_cycle();
    test_back_to_back();
    test_rx();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
